// File: rtl/clkdiv_sel_noglitch.sv
// Glitch-free programmable clock divider with run-time ratio select; 1-cycle start latency,
// ratio/enable changes applied only at the end of a full low half so DATA_O never runts.
module clkdiv_sel_noglitch #(
  parameter int NUM_SEL   = 4,
  parameter int SEL_WIDTH = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         MCLK_I,
  input  logic                         RST_N_I,
  input  logic [NUM_SEL*CNT_WIDTH-1:0] HALF_I,
  input  logic [SEL_WIDTH-1:0]         SEL_I,
  input  logic                         EN_I,
  output logic                         DATA_O,
  output logic [SEL_WIDTH-1:0]         SEL_O,
  output logic                         RISE_O,
  output logic                         FALL_O,
  output logic                         BUSY_O
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0]   half_reg, half_nxt;
  logic [SEL_WIDTH-1:0]   sel_nxt;
  logic                   data_nxt, rise_nxt, fall_nxt;
  logic [SEL_WIDTH-1:0]   eff_sel;
  logic [CNT_WIDTH-1:0]   half_sel;

  // Out-of-range channel requests fall back to channel 0.
  always_comb begin
    eff_sel  = (int'(SEL_I) < NUM_SEL) ? SEL_I : '0;
    half_sel = HALF_I[int'(eff_sel)*CNT_WIDTH +: CNT_WIDTH];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    half_nxt  = half_reg;
    sel_nxt   = SEL_O;
    data_nxt  = DATA_O;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      IDLE: begin
        data_nxt = 1'b0;
        if (EN_I) begin
          state_nxt = HIGH;
          data_nxt  = 1'b1;
          sel_nxt   = eff_sel;
          half_nxt  = half_sel;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end
      end
      HIGH: begin
        if (cnt != half_reg) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          state_nxt = LOW;
          data_nxt  = 1'b0;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
        end
      end
      LOW: begin
        if (cnt != half_reg) begin
          cnt_nxt = cnt + 1'b1;
        end else if (!EN_I) begin
          state_nxt = IDLE;
        end else begin
          // Only point where select and half period are re-sampled.
          state_nxt = HIGH;
          data_nxt  = 1'b1;
          sel_nxt   = eff_sel;
          half_nxt  = half_sel;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        data_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MCLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state    <= IDLE;
      cnt      <= '0;
      half_reg <= '0;
      SEL_O    <= '0;
      DATA_O   <= 1'b0;
      RISE_O   <= 1'b0;
      FALL_O   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      half_reg <= half_nxt;
      SEL_O    <= sel_nxt;
      DATA_O   <= data_nxt;
      RISE_O   <= rise_nxt;
      FALL_O   <= fall_nxt;
    end
  end

  assign BUSY_O = (state != IDLE) && ((eff_sel != SEL_O) || !EN_I);

endmodule

// File: tb/tb_clkdiv_sel_noglitch.sv
// Bench for clkdiv_sel_noglitch: period-position reference model checked every cycle,
// directed literal scenarios, and a randomized run of select/enable/half-table changes.
module tb_clkdiv_sel_noglitch;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int CW = 8;

  logic           MCLK_I;
  logic           RST_N_I;
  logic [NS*CW-1:0] HALF_I;
  logic [SW-1:0]  SEL_I;
  logic           EN_I;
  logic           DATA_O;
  logic [SW-1:0]  SEL_O;
  logic           RISE_O;
  logic           FALL_O;
  logic           BUSY_O;

  int total = 0;
  int pass  = 0;

  clkdiv_sel_noglitch #(.NUM_SEL(NS), .SEL_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .MCLK_I(MCLK_I), .RST_N_I(RST_N_I), .HALF_I(HALF_I), .SEL_I(SEL_I), .EN_I(EN_I),
    .DATA_O(DATA_O), .SEL_O(SEL_O), .RISE_O(RISE_O), .FALL_O(FALL_O), .BUSY_O(BUSY_O)
  );

  initial begin
    MCLK_I = 1'b0;
    forever #5 MCLK_I = ~MCLK_I;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int eff(input int s);
    return (s < NS) ? s : 0;
  endfunction

  function automatic int half_of(input int ch);
    return int'((HALF_I >> (ch * CW)) & 24'hFF);
  endfunction

  // Reference model: position t within the current output period of length 2*(h+1).
  bit m_run;
  int m_t, m_h, m_sel;

  always @(posedge MCLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      m_run = 0; m_t = 0; m_h = 0; m_sel = 0;
    end else if (!m_run || m_t == 2 * m_h + 1) begin
      if (EN_I) begin
        m_run = 1; m_t = 0;
        m_sel = eff(int'(SEL_I));
        m_h   = half_of(m_sel);
      end else begin
        m_run = 0;
      end
    end else begin
      m_t = m_t + 1;
    end
  end

  always @(negedge MCLK_I) begin
    chk("data", int'(DATA_O), int'(m_run && m_t <= m_h));
    chk("rise", int'(RISE_O), int'(m_run && m_t == 0));
    chk("fall", int'(FALL_O), int'(m_run && m_t == m_h + 1));
    chk("sel",  int'(SEL_O),  m_sel);
    chk("busy", int'(BUSY_O), int'(m_run && (eff(int'(SEL_I)) != m_sel || !EN_I)));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge MCLK_I);
    #2;
  endtask

  task automatic set_half(input int ch, input int v);
    HALF_I[ch*CW +: CW] = v[CW-1:0];
  endtask

  task automatic wait_rise(input int sel, input string nm);
    bit found;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cyc(1);
      if (RISE_O && int'(SEL_O) == sel) found = 1;
    end
    chk({nm, "_timeout"}, int'(found), 1);
  endtask

  initial begin
    RST_N_I = 1'b0; EN_I = 1'b0; SEL_I = '0; HALF_I = '0;
    #3;
    chk("rst_data", int'(DATA_O), 0);
    chk("rst_sel",  int'(SEL_O), 0);
    chk("rst_busy", int'(BUSY_O), 0);
    cyc(2);
    RST_N_I = 1'b1;
    cyc(1);
    chk("idle_data", int'(DATA_O), 0);

    // Divide-by-2 on channel 0.
    set_half(0, 0); set_half(1, 4); set_half(2, 1);
    EN_I = 1'b1;
    cyc(1); chk("d2_data0", int'(DATA_O), 1); chk("d2_rise0", int'(RISE_O), 1);
    cyc(1); chk("d2_data1", int'(DATA_O), 0); chk("d2_fall1", int'(FALL_O), 1);
    cyc(1); chk("d2_data2", int'(DATA_O), 1); chk("d2_rise2", int'(RISE_O), 1);
    chk("d2_sel", int'(SEL_O), 0);

    // Select switch mid-HIGH: old period completes as 3/3, then 5/5.
    set_half(0, 2);
    wait_rise(0, "sw_sync");
    cyc(1);
    SEL_I = 2'd1;
    #1 chk("sw_busy_req", int'(BUSY_O), 1);
    cyc(2); chk("sw_fall_old", int'(FALL_O), 1); chk("sw_sel_old", int'(SEL_O), 0);
    cyc(3); chk("sw_rise_new", int'(RISE_O), 1); chk("sw_sel_new", int'(SEL_O), 1);
    chk("sw_busy_done", int'(BUSY_O), 0);
    cyc(4); chk("sw_high5", int'(DATA_O), 1);
    cyc(1); chk("sw_fall_new", int'(FALL_O), 1);

    // Stop one cycle into HIGH with half=3.
    set_half(0, 3); SEL_I = 2'd0;
    wait_rise(0, "stop_sync");
    cyc(1);
    EN_I = 1'b0;
    cyc(2); chk("stop_high4", int'(DATA_O), 1);
    cyc(1); chk("stop_fall", int'(FALL_O), 1); chk("stop_busy", int'(BUSY_O), 1);
    cyc(3); chk("stop_low4", int'(DATA_O), 0); chk("stop_busy_end", int'(BUSY_O), 1);
    cyc(1); chk("stop_idle_busy", int'(BUSY_O), 0); chk("stop_idle_rise", int'(RISE_O), 0);
    cyc(2); chk("stop_held", int'(DATA_O), 0);
    EN_I = 1'b1;
    cyc(1); chk("restart_rise", int'(RISE_O), 1);

    // Out-of-range select maps to channel 0.
    SEL_I = 2'd3;
    #1 chk("oor_busy", int'(BUSY_O), 0);
    wait_rise(0, "oor_rise");
    chk("oor_sel", int'(SEL_O), 0);

    // Max half period, with the active channel's half changed mid-period.
    set_half(1, 255); SEL_I = 2'd1;
    wait_rise(1, "max_sync");
    cyc(10); set_half(1, 5);
    cyc(245); chk("max_high256", int'(DATA_O), 1);
    cyc(1);   chk("max_fall", int'(FALL_O), 1);
    cyc(255); chk("max_low256", int'(DATA_O), 0);
    cyc(1);   chk("max_rise", int'(RISE_O), 1);
    cyc(5);   chk("new_half_high", int'(DATA_O), 1);
    cyc(1);   chk("new_half_fall", int'(FALL_O), 1);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) SEL_I = SW'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) set_half(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 6)));
      if ($urandom_range(0, 29) == 0) EN_I = ~EN_I;
      cyc(1);
    end

    // Asynchronous reset right at a rise.
    EN_I = 1'b1; SEL_I = 2'd1; set_half(1, 2);
    wait_rise(1, "rst_sync");
    chk("rst_pre_data", int'(DATA_O), 1);
    RST_N_I = 1'b0;
    #1;
    chk("arst_data", int'(DATA_O), 0);
    chk("arst_rise", int'(RISE_O), 0);
    chk("arst_fall", int'(FALL_O), 0);
    chk("arst_sel",  int'(SEL_O), 0);
    cyc(2);
    RST_N_I = 1'b1;
    cyc(4);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/clkdiv_sel_noglitch.md
# clkdiv_sel_noglitch

Parametrised glitch-free clock divider and selector. It produces one divided clock, DATA_O, from a single master clock, choosing among NUM_SEL programmable divide ratios. Ratio changes and enable/disable take effect only at half-period boundaries, so DATA_O never shows a runt pulse. It sits in the clock-generation area, feeding audio bit/frame clocks where ratios change at run time.

## Interface
- NUM_SEL, 4: number of selectable ratio channels (≥2)
- SEL_WIDTH, 2: width of SEL_I/SEL_O; must satisfy 2**SEL_WIDTH ≥ NUM_SEL
- CNT_WIDTH, 8: half-period counter width

- MCLK_I  input  1  master clock; all logic on rising edge
- RST_N_I  input  1  asynchronous active-low reset
- HALF_I  input  NUM_SEL*CNT_WIDTH  packed half-period table; channel k = HALF_I[k*CNT_WIDTH +: CNT_WIDTH]; half period = value+1 MCLK cycles
- SEL_I  input  SEL_WIDTH  requested channel; values ≥ NUM_SEL select channel 0
- EN_I  input  1  output enable; 1 = run, 0 = stop low
- DATA_O  output  1  divided clock, registered
- SEL_O  output  SEL_WIDTH  channel currently driving DATA_O
- RISE_O  output  1  one-cycle strobe, high in the cycle DATA_O first reads 1
- FALL_O  output  1  one-cycle strobe, high in the cycle DATA_O first reads 0 after a high half
- BUSY_O  output  1  combinational; a select change or stop is pending

## Operation
- Reset (asynchronous): STATE=IDLE, DATA_O=0, CNT=0, SEL_O=0, HALF_REG=0, RISE_O=0, FALL_O=0. BUSY_O evaluates to 0.
- Each state is a registered transition. SEL_REG drives SEL_O. HALF_REG holds the latched half period.
- IDLE:
  - DATA_O=0.
  - If EN_I=1: go to HIGH, DATA_O<=1, SEL_REG<=eff(SEL_I), HALF_REG<=HALF_I[eff(SEL_I)], CNT<=0, RISE_O<=1.
- HIGH:
  - If CNT≠HALF_REG: CNT<=CNT+1.
  - Else: go to LOW, DATA_O<=0, CNT<=0, FALL_O<=1.
- LOW:
  - If CNT≠HALF_REG: CNT<=CNT+1.
  - Else if EN_I=0: go to IDLE; DATA_O stays 0.
  - Else: go to HIGH with the same updates as the IDLE→HIGH transition, re-sampling SEL_I and HALF_I.
- SEL_I and HALF_I are sampled only at the LOW→HIGH or IDLE→HIGH transition. Changes in between are ignored until then. A switch therefore always completes a full period of the old ratio.
- EN_I is sampled only at the end of a LOW half. Deassertion during HIGH finishes the high half and the low half, then stops. A re-assertion before that point cancels the stop.
- BUSY_O = (STATE≠IDLE) & ((eff(SEL_I)≠SEL_REG) | ~EN_I).
- eff(s) = s if s<NUM_SEL, else 0.
- Arithmetic:
  - CNT is unsigned CNT_WIDTH bits and never wraps, since it is compared for equality with HALF_REG.
  - HALF=0 gives divide-by-2.
  - HALF=2**CNT_WIDTH−1 gives divide-by-2**(CNT_WIDTH+1).
- RISE_O and FALL_O are 0 in every cycle not listed above.

## Timing
- Start latency: EN_I sampled high in IDLE at edge n → DATA_O=1 and RISE_O=1 after edge n.
- Output period = 2*(HALF_REG+1) MCLK cycles, 50 % duty cycle, for every ratio.
- Select latency: the new ratio starts at the first rising DATA_O after the request. The worst case is one full old period plus one cycle.
- Stop latency: DATA_O ends low. There is no high phase shorter than HALF_REG+1 and no low phase shorter than HALF_REG+1.
- The same SEL_I re-requested mid-period deasserts BUSY_O combinationally. No action is taken.
- Simultaneous SEL change and EN_I=0 at the end of LOW: stop wins. SEL_O keeps the old value. The new SEL_I is applied on the next start.
- Reset mid-HIGH forces DATA_O low asynchronously. That runt is accepted and is the only permitted one.

## Test plan
- Reset, EN_I=1, SEL_I=0, HALF ch0=0 → after 1 cycle DATA_O toggles every cycle (divide-by-2); RISE_O on every 2nd cycle; SEL_O=0.
- Running ch0 HALF=2. Switch SEL_I to 1 (HALF=4) mid-HIGH → current period completes as 3 high/3 low. Then 5 high/5 low. BUSY_O=1 from the request until SEL_O=1.
- Running HALF=3. Drop EN_I one cycle into HIGH → 4 high, 4 low, then DATA_O held 0 and IDLE. BUSY_O high until entry to IDLE. Re-assert → RISE_O the next cycle.
- SEL_I=3 with NUM_SEL=3 → channel 0 used, SEL_O=0, BUSY_O=0 while the request is held.
- Change HALF_I of the active channel mid-period → the current period keeps the old value and the new value applies from the next rise. Also check HALF=255 with CNT_WIDTH=8 → 256 high/256 low.
- Assert RST_N_I low mid-HIGH → DATA_O, RISE_O, FALL_O, SEL_O read 0 immediately, without an MCLK edge.
